// File: rtl/exception_controller.sv
// Exception entry/return sequencer: syncs and edge-detects sources,
// masks/prioritises them, handshakes with the CPU, captures EPC.
//
// Ports:
//   clk, rst          clock; async active-low reset
//   exp_src           raw asynchronous exception sources
//   mask_we/wdata     mask register write (1 = source disabled)
//   pc_in             PC at the acknowledging instruction boundary
//   exc_ack, eret     CPU accept / exception return strobes
//   exc_req           request to the CPU
//   exc_cause         index of requested/serviced source
//   handler_addr      handler vector for exc_cause
//   epc               PC captured at acknowledge
//   in_service        handler executing
//   pending, mask     latched events / current mask
//   exc_count         exceptions taken (wraps)
module exception_controller #(
    parameter int unsigned NUM_SRC    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] exp_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic [31:0]        pc_in,
    input  logic               exc_ack,
    input  logic               eret,
    output logic               exc_req,
    output logic [1:0]         exc_cause,
    output logic [31:0]        handler_addr,
    output logic [31:0]        epc,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic [31:0]        exc_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_req;
    logic               r_in_service;
    logic [1:0]         r_cause;
    logic [31:0]        r_epc;
    logic [31:0]        r_count;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_clr;
    logic [1:0]         w_prio;
    logic               w_take;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_elig = r_pending & ~r_mask;
    assign w_take = (r_state == S_REQ) && exc_ack;

    // Bit of the cause being acknowledged this cycle
    assign w_clr = w_take ? (NUM_SRC'(1) << r_cause) : '0;

    // Lowest eligible index wins
    always_comb begin
        w_prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_prio = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= exp_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // A new edge outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_in_service <= 1'b0;
            r_cause      <= '0;
            r_epc        <= '0;
            r_count      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_cause <= w_prio;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Cause stays frozen until the CPU accepts
                    if (exc_ack) begin
                        r_epc        <= pc_in;
                        r_count      <= r_count + 32'd1;
                        r_req        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (eret) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_req        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign exc_req      = r_req;
    assign exc_cause    = r_cause;
    assign handler_addr = VEC_BASE + 32'(r_cause) * VEC_STRIDE;
    assign epc          = r_epc;
    assign in_service   = r_in_service;
    assign pending      = r_pending;
    assign mask         = r_mask;
    assign exc_count    = r_count;

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Sequences exception entry and return for single_cycle_cpu_top.
- Takes the raw exception sources (expSrc0..2 at the top level, bundled as exp_src), synchronises and edge-detects them, and holds them as pending bits.
- Masks and prioritises pending sources, then runs a request/acknowledge handshake with the CPU at instruction boundaries.
- Captures the EPC, supplies the handler vector, blocks nesting until eret, and counts taken exceptions for the stats outputs.

Parameters:
NUM_SRC, 3, number of exception sources (cause width = 2 bits, valid for NUM_SRC <= 4)
VEC_BASE, 32'h0000_0800, handler address for cause 0
VEC_STRIDE, 32'h0000_0020, address spacing between handlers

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
exp_src  input  NUM_SRC  raw exception sources, asynchronous level inputs
mask_we  input  1  mask write strobe, one cycle
mask_wdata  input  NUM_SRC  new mask value (1 = source disabled)
pc_in  input  32  PC of the instruction at the boundary where ack occurs
exc_ack  input  1  CPU accepts the exception this cycle
eret  input  1  CPU executes exception return, one cycle
exc_req  output  1  exception request to CPU
exc_cause  output  2  index of the requested or serviced source
handler_addr  output  32  VEC_BASE + exc_cause*VEC_STRIDE
epc  output  32  PC captured at acknowledge
in_service  output  1  handler executing
pending  output  NUM_SRC  latched unserviced events
mask  output  NUM_SRC  current mask register
exc_count  output  32  number of exceptions taken

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - All outputs and internal flops cleared: exc_req=0, exc_cause=0, handler_addr=VEC_BASE, epc=0, in_service=0, pending=0, mask=0 (all enabled), exc_count=0.
  - Synchroniser and edge flops cleared; FSM returns to IDLE.
  - Applies mid-handshake too: exc_req drops immediately, with no clock required.
- Input conditioning:
  - Each exp_src bit passes through a 2-flop synchroniser, then a rising-edge detector that registers the previous synchronised value.
  - A rising input that meets setup before edge 1 sets pending[i] at edge 3.
  - A level held high produces exactly one event; a new event requires a low of at least 1 cycle.
- Pending:
  - Set by an edge event regardless of mask or state.
  - Cleared only by an accepted acknowledge of that cause.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Mask:
  - mask <= mask_wdata on mask_we, in any state.
  - eligible = pending & ~mask.
  - Priority: lowest index wins.
- FSM, states IDLE, REQ, SERVICE:
  - IDLE:
    - If eligible != 0: latch exc_cause = priority-encode(eligible) and go to REQ; exc_req=1 from the next cycle.
    - In IDLE, exc_cause holds its last value.
  - REQ:
    - exc_req=1.
    - exc_cause and handler_addr are frozen, even if a higher-priority source arrives or the cause is masked afterwards.
    - On exc_ack: epc <= pc_in, pending[exc_cause] <= 0, exc_count <= exc_count+1 (wraps 0xFFFF_FFFF to 0), go to SERVICE. exc_req=0 in the cycle after ack.
  - SERVICE:
    - in_service=1, exc_req=0.
    - New events only accumulate in pending (no nesting).
    - On eret: go to IDLE. The earliest new exc_req comes 2 cycles after the eret edge (IDLE evaluates, then REQ).
    - epc and exc_cause are held until the next acknowledge.
- Ignored inputs: exc_ack outside REQ; eret outside SERVICE; exc_ack and eret together in REQ (only the ack acts).
- handler_addr: combinational from the registered exc_cause; 32-bit wrap-around arithmetic.

Test Plan:
- Single event: release rst, drive exp_src=3'b001 high for 2 cycles → pending=3'b001 at edge 3, then exc_req=1 with exc_cause=0 and handler_addr=0x800. Assert exc_ack with pc_in=0x0000_0040 → epc=0x40, exc_count=1, in_service=1, pending=0.
- Simultaneous events: exp_src=3'b110 → cause 1 first (handler 0x820). After ack and eret → exc_req for cause 2 (handler 0x840), exc_count=2 after its ack.
- Masking: write mask=3'b001, pulse src0 → pending[0]=1, exc_req stays 0 for 10 cycles. Write mask=0 → exc_req=1 with cause 0 two cycles later.
- Event during service: in SERVICE, pulse src2 → pending[2]=1, exc_req=0. eret → exc_req=1 with cause 2. A stray exc_ack in SERVICE leaves exc_count unchanged.
- Held level and frozen cause: hold exp_src[1] high for 50 cycles → exactly one exception taken. In REQ for cause 1, pulse src0 → cause stays 1 until ack; cause 0 is taken after eret.
- Reset mid-operation: drop rst while exc_req=1 between clock edges → exc_req=0 and pending=0 before the next edge. After release, no request without a new event.
